// File: rtl/dm_store.sv
// rtl/dm_store.sv - word-organised data memory with byte/half/word store merge
module dm_store #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  st_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        align_err,
    output logic        range_err,
    output logic [31:0] wr_cnt,
    output logic [31:0] last_waddr,
    output logic [31:0] last_wword
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_BYTE = 2'b10;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wi;
    logic [1:0]        lane;
    logic [31:0]       old_word;
    logic [31:0]       merged;
    logic              aligned;
    logic              in_range;
    logic              commit;

    assign wi       = addr[ADDR_W+1:2];
    assign lane     = addr[1:0];
    assign old_word = mem[wi];

    // Reads ignore st_type and the upper address bits; they always see the stored word.
    assign rdata = old_word;

    assign in_range = (addr[31:ADDR_W+2] == '0);
    assign commit   = we && aligned && in_range;

    // Alignment check per store width; the reserved encoding is never accepted.
    always_comb begin
        aligned = 1'b0;
        case (st_type)
            ST_WORD: aligned = (lane == 2'b00);
            ST_HALF: aligned = (lane[0] == 1'b0);
            ST_BYTE: aligned = 1'b1;
            default: aligned = 1'b0;
        endcase
    end

    // Merge the narrowed store lane into the currently stored word.
    always_comb begin
        merged = old_word;
        case (st_type)
            ST_WORD: merged = wdata;
            ST_HALF: begin
                if (lane[1]) merged = {wdata[15:0], old_word[15:0]};
                else         merged = {old_word[31:16], wdata[15:0]};
            end
            ST_BYTE: begin
                case (lane)
                    2'd0:    merged = {old_word[31:8], wdata[7:0]};
                    2'd1:    merged = {old_word[31:16], wdata[7:0], old_word[7:0]};
                    2'd2:    merged = {old_word[31:24], wdata[7:0], old_word[15:0]};
                    default: merged = {wdata[7:0], old_word[23:0]};
                endcase
            end
            default: merged = old_word;
        endcase
    end

    // Commit accepted stores, track the last write, and latch sticky error flags for rejected ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            align_err  <= 1'b0;
            range_err  <= 1'b0;
            wr_cnt     <= '0;
            last_waddr <= '0;
            last_wword <= '0;
        end else begin
            if (commit) begin
                mem[wi]    <= merged;
                wr_cnt     <= wr_cnt + 32'd1;
                last_waddr <= {addr[31:2], 2'b00};
                last_wword <= merged;
`ifndef SYNTHESIS
                $display("@%08h: *%08h <= %08h", pc, {addr[31:2], 2'b00}, merged);
`endif
            end
            if (we && !aligned)  align_err <= 1'b1;
            if (we && !in_range) range_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dm_store.sv
// tb/tb_dm_store.sv - self-checking bench for dm_store
module tb_dm_store;

    localparam int AW     = 10;
    localparam int DEPTH  = 1 << AW;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  st_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        align_err;
    logic        range_err;
    logic [31:0] wr_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wword;

    dm_store #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .st_type    (st_type),
        .addr       (addr),
        .wdata      (wdata),
        .pc         (pc),
        .rdata      (rdata),
        .align_err  (align_err),
        .range_err  (range_err),
        .wr_cnt     (wr_cnt),
        .last_waddr (last_waddr),
        .last_wword (last_wword)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Byte-addressed reference model, little-endian within each word.
    logic [7:0]  bmem [NBYTES];
    logic        m_al;
    logic        m_rg;
    logic [31:0] m_cnt;
    logic [31:0] m_la;
    logic [31:0] m_lw;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int base;
        base = int'((a % NBYTES) / 4) * 4;
        return {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NBYTES; i++) bmem[i] = 8'h00;
        m_al = 1'b0; m_rg = 1'b0;
        m_cnt = '0; m_la = '0; m_lw = '0;
    endtask

    task automatic m_store(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        int  size;
        bit  ok_align;
        bit  ok_range;
        if (!w) return;
        size = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : (s == 2'd2) ? 1 : 0;
        ok_align = (size != 0) && ((a % size) == 0);
        ok_range = (a < NBYTES);
        if (ok_align && ok_range) begin
            for (int b = 0; b < size; b++) bmem[int'(a) + b] = d[8*b +: 8];
            m_cnt = m_cnt + 1;
            m_la  = a - (a % 4);
            m_lw  = m_read(a);
        end else begin
            if (!ok_align) m_al = 1'b1;
            if (!ok_range) m_rg = 1'b1;
        end
    endtask

    task automatic cycle(input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        we = w; st_type = s; addr = a; wdata = d; pc = p;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_la;
        logic [31:0] exp_lw;
        logic        exp_al;
        logic        exp_rg;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t tbl [10];

    initial begin
        reset = 1'b0; we = 1'b0; st_type = 2'b00; addr = '0; wdata = '0; pc = '0;

        tbl[0] = '{"sw_0",        1, 2'd0, 32'h0000_0000, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h00, 32'h0BAD_F00D, 0, 0, 1};
        tbl[1] = '{"sw_10",       1, 2'd0, 32'h0000_0010, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'h10, 32'hAABB_CCDD, 0, 0, 2};
        tbl[2] = '{"sb_11",       1, 2'd2, 32'h0000_0011, 32'h0000_00EE, 32'hAABB_EEDD, 32'h10, 32'hAABB_EEDD, 0, 0, 3};
        tbl[3] = '{"sb_13",       1, 2'd2, 32'h0000_0013, 32'h0000_0011, 32'h11BB_EEDD, 32'h10, 32'h11BB_EEDD, 0, 0, 4};
        tbl[4] = '{"sw_20",       1, 2'd0, 32'h0000_0020, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h20, 32'hFFFF_FFFF, 0, 0, 5};
        tbl[5] = '{"sh_22",       1, 2'd1, 32'h0000_0022, 32'h9ABC_1234, 32'h1234_FFFF, 32'h20, 32'h1234_FFFF, 0, 0, 6};
        tbl[6] = '{"sh_21_mis",   1, 2'd1, 32'h0000_0021, 32'h0000_5555, 32'h1234_FFFF, 32'h20, 32'h1234_FFFF, 1, 0, 6};
        tbl[7] = '{"sw_26_mis",   1, 2'd0, 32'h0000_0026, 32'h7777_7777, 32'h0000_0000, 32'h20, 32'h1234_FFFF, 1, 0, 6};
        tbl[8] = '{"rsv_30",      1, 2'd3, 32'h0000_0030, 32'h5A5A_5A5A, 32'h0000_0000, 32'h20, 32'h1234_FFFF, 1, 0, 6};
        tbl[9] = '{"sw_1000_oor", 1, 2'd0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h20, 32'h1234_FFFF, 1, 1, 6};

        // Reset clear
        do_reset();
        check("reset_rdata0", rdata, 32'h0);
        cycle(1, 2'd0, 32'h0, 32'h1234_5678, 32'h100);
        check("pre_reset_word", rdata, 32'h1234_5678);
        do_reset();
        addr = 32'h0;
        #1;
        check("reset_clr_rdata", rdata, 32'h0);
        check("reset_clr_cnt", wr_cnt, 32'h0);
        check("reset_clr_al", {31'b0, align_err}, 32'h0);
        check("reset_clr_rg", {31'b0, range_err}, 32'h0);
        check("reset_clr_lw", last_wword, 32'h0);
        check("reset_clr_la", last_waddr, 32'h0);

        // Directed table, back-to-back on consecutive edges
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].we, tbl[i].st, tbl[i].addr, tbl[i].wdata, 32'h1000 + 32'(i * 4));
            check({tbl[i].name, "_rdata"}, rdata, tbl[i].exp_rdata);
            check({tbl[i].name, "_cnt"}, wr_cnt, tbl[i].exp_cnt);
            check({tbl[i].name, "_la"}, last_waddr, tbl[i].exp_la);
            check({tbl[i].name, "_lw"}, last_wword, tbl[i].exp_lw);
            check({tbl[i].name, "_al"}, {31'b0, align_err}, {31'b0, tbl[i].exp_al});
            check({tbl[i].name, "_rg"}, {31'b0, range_err}, {31'b0, tbl[i].exp_rg});
        end
        @(negedge clk); we = 1'b0;

        // Reserved store type alone sets only align_err
        do_reset();
        cycle(1, 2'd3, 32'h0000_0040, 32'h1111_1111, 32'h200);
        check("rsv_only_al", {31'b0, align_err}, 32'h1);
        check("rsv_only_rg", {31'b0, range_err}, 32'h0);
        check("rsv_only_cnt", wr_cnt, 32'h0);
        check("rsv_only_mem", rdata, 32'h0);

        // Out-of-range alone sets only range_err
        do_reset();
        cycle(1, 2'd0, 32'h0000_1000, 32'h2222_2222, 32'h204);
        check("oor_only_al", {31'b0, align_err}, 32'h0);
        check("oor_only_rg", {31'b0, range_err}, 32'h1);
        check("oor_only_mem0", rdata, 32'h0);

        // Read timing: old word during the store cycle, new word after
        do_reset();
        @(negedge clk);
        we = 1'b1; st_type = 2'd0; addr = 32'h40; wdata = 32'hCAFE_BABE; pc = 32'h3000;
        #1;
        check("rt_same_cycle", rdata, 32'h0);
        @(posedge clk);
        #1;
        check("rt_next_cycle", rdata, 32'hCAFE_BABE);
        check("rt_la", last_waddr, 32'h40);
        @(negedge clk); we = 1'b0;

        // Reset has priority over a store in the same cycle
        @(negedge clk);
        reset = 1'b1; we = 1'b1; st_type = 2'd0; addr = 32'h50; wdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        check("rst_pri_rdata", rdata, 32'h0);
        check("rst_pri_cnt", wr_cnt, 32'h0);
        @(negedge clk); reset = 1'b0; we = 1'b0;

        // Randomised stores against the byte-level model
        do_reset();
        m_reset();
        for (int n = 0; n < 600; n++) begin
            logic        w;
            logic [1:0]  s;
            logic [31:0] a;
            logic [31:0] d;
            if (n % 150 == 149) begin
                do_reset();
                m_reset();
            end
            w = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, 127)) | (32'($urandom_range(1, 1023)) << 12);
                1, 2:    a = 32'($urandom_range(0, NBYTES - 1));
                default: a = 32'($urandom_range(0, 63));
            endcase
            d = $urandom;
            cycle(w, s, a, d, $urandom);
            m_store(w, s, a, d);
            check("rnd_rdata", rdata, m_read(a));
            check("rnd_cnt", wr_cnt, m_cnt);
            check("rnd_la", last_waddr, m_la);
            check("rnd_lw", last_wword, m_lw);
            check("rnd_al", {31'b0, align_err}, {31'b0, m_al});
            check("rnd_rg", {31'b0, range_err}, {31'b0, m_rg});
        end
        @(negedge clk); we = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_store.md
# dm_store

Word-organised data memory with a sub-word store path for the single-cycle MIPS datapath. It narrows 32-bit register data into byte, halfword or word stores by merging the stored lane into the addressed word on the clock edge; this is the inverse of immediate and load extension. It sits in the MEM stage and is driven by the ALU result (address), the `rt` register value (data), and controller decode of `sw`/`sh`/`sb`. Reads are combinational full words; load lane selection and extension are handled downstream.

## Interface
- `ADDR_W`, default 10: word-address width. Memory holds 2^ADDR_W 32-bit words, so the byte-address space is 0 to 4·2^ADDR_W−1.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high. Clears all state.
- `we` input 1: store enable, decoded from `sw`, `sh` or `sb`.
- `st_type` input 2: 00 = word, 01 = half, 10 = byte, 11 = reserved.
- `addr` input 32: byte address.
- `wdata` input 32: store data, which is the `rt` value. Only the low 8, 16 or 32 bits are used.
- `pc` input 32: PC of the storing instruction, used only for the write log.
- `rdata` output 32: word at `addr[ADDR_W+1:2]`. Combinational.
- `align_err` output 1: sticky flag, set by a rejected misaligned or reserved store.
- `range_err` output 1: sticky flag, set by a rejected out-of-range store.
- `wr_cnt` output 32: count of committed stores.
- `last_waddr` output 32: word-aligned byte address of the last committed store.
- `last_wword` output 32: full merged word written by the last committed store.

## Operation
- Word index `wi = addr[ADDR_W+1:2]`. Lane `k = addr[1:0]`.
- Aligned store conditions:
  - word: `k == 0`
  - half: `addr[0] == 0`
  - byte: always aligned
  - `st_type == 11` is never aligned.
- In-range condition: `addr[31:ADDR_W+2] == 0`.
- Merged word (`old = mem[wi]`):
  - word: `wdata`
  - half: bits `[16·addr[1]+15 : 16·addr[1]]` become `wdata[15:0]`; the other half keeps `old`.
  - byte: bits `[8k+7 : 8k]` become `wdata[7:0]`; the other three bytes keep `old`.
- Commit occurs when `we && aligned && in_range`. On commit:
  - `mem[wi]` gets the merged word.
  - `wr_cnt` increments by 1, wrapping from 0xFFFFFFFF to 0.
  - `last_waddr` gets `{addr[31:2],2'b00}`.
  - `last_wword` gets the merged word.
  - Simulation log prints `@<pc>: *<last_waddr> <= <merged>` using 8-digit hex via `$display`.
- Rejection occurs when `we` is high but the store is not committed:
  - Memory and all counters are unchanged. No log line is printed.
  - A misaligned or reserved store sets `align_err`.
  - An in-range violation sets `range_err`. If a store is both misaligned and out of range, both flags are set.
- With `we` low, nothing changes. `st_type` and `addr` are don't-care.
- The read path ignores `st_type`. It returns `mem[wi]` for any `addr`, including out-of-range, where the upper address bits are ignored.

## Timing
- On reset, sampled at a rising edge:
  - every memory word becomes 0x00000000
  - `align_err` = 0, `range_err` = 0
  - `wr_cnt` = 0
  - `last_waddr` = 0
  - `last_wword` = 0
- Reset has priority over `we` in the same cycle. No commit and no log line occur.
- Stores take effect at the rising edge where `we` is sampled, so write latency is 1 cycle.
- In the store cycle, `rdata` shows the old word. From the following cycle it shows the merged word.
- Back-to-back sub-word stores to the same word on consecutive cycles merge cumulatively. Each merge reads the value committed at the previous edge.
- Error flags stay sticky until `reset`. They go high at the edge that samples the bad store.
- Reset asserted mid-sequence discards nothing already committed before that edge. The reset edge itself clears everything.

## Test plan
- **Reset clear:** write `sw` 0x12345678 to 0x0, then pulse `reset`, then read 0x0. Expect `rdata` = 0, `wr_cnt` = 0, both error flags = 0.
- **Byte merge:**
  - `sw` 0xAABBCCDD to 0x10
  - `sb` `wdata` = 0x000000EE to 0x11, giving 0xAABBEEDD
  - `sb` 0x11 to 0x13, giving 0x11BBEEDD
  - Expect `wr_cnt` = 3 and `last_wword` = 0x11BBEEDD.
- **Half merge:** `sw` 0xFFFFFFFF to 0x20, then `sh` `wdata` = 0x9ABC1234 to 0x22. Expect 0x1234FFFF. The upper `wdata` bits are ignored.
- **Misalignment:**
  - `sh` to 0x21, then `sw` to 0x26.
  - Expect memory unchanged, `wr_cnt` unchanged, `align_err` = 1 after the first bad edge, `range_err` = 0.
  - `st_type` = 11 with `we` = 1 also sets `align_err`.
- **Range:** with `ADDR_W` = 10, `sw` to 0x00001000. Expect no write, `range_err` = 1, and 0x0 still reading its prior value.
- **Read timing:** in the same cycle as `sw` 0xCAFEBABE to 0x40, `rdata` is the old word. The next cycle `rdata` = 0xCAFEBABE. The log line is `@00003000: *00000040 <= cafebabe` when `pc` = 0x3000.
